// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares a single UART byte transmitter between NUM_REQ byte producers.
//   Requesters are served round-robin, one byte per grant. Each byte is
//   launched with a one-cycle tx_start pulse, then the arbiter waits for
//   tx_done. An idle-line gap follows each completed frame. A busy timeout
//   aborts a frame whose tx_done never arrives. Both the gap and the timeout
//   are counted in baud oversample ticks (b_tick).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   b_tick       one-cycle baud oversample tick (16 per bit)
//   req_valid    per-requester byte-available flags
//   req_data     packed bytes, requester i on [8i+7:8i]
//   req_ready    one-hot, one-cycle accept pulse (high during LOAD)
//   tx_start     one-cycle start pulse to the transmitter (high during LOAD)
//   tx_data      byte being sent; stable from LOAD until back in IDLE
//   tx_done      one-cycle end-of-stop-bit pulse from the transmitter
//   grant_id     index of the current or most recently granted requester
//   active       high in every state except IDLE
//   err_timeout  sticky busy-timeout flag
//   err_clr      clears err_timeout (a simultaneous timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 352
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       b_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout,
  input  logic                       err_clr
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BUSY_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, GAP} state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     last_ptr, last_ptr_d;
  logic [BUSY_W-1:0]   busy_cnt, busy_cnt_d;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;

  logic [NUM_REQ-1:0]  req_ready_d;
  logic                tx_start_d;
  logic [7:0]          tx_data_d;
  logic [ID_W-1:0]     grant_id_d;
  logic                active_d;
  logic                err_timeout_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_id;
  logic [7:0]          win_data;

  // Round-robin pick: scan last_ptr+1, last_ptr+2, ... modulo NUM_REQ and
  // take the first valid requester.
  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    win_data  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_id = ID_W'((int'(last_ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) win_data = req_data[8*i +: 8];
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d       = state;
    last_ptr_d    = last_ptr;
    busy_cnt_d    = busy_cnt;
    gap_cnt_d     = gap_cnt;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data;
    grant_id_d    = grant_id;
    err_timeout_d = err_timeout;

    // Clear first so a timeout in the same cycle overrides it.
    if (err_clr) err_timeout_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_d     = LOAD;
          grant_id_d  = win_id;
          last_ptr_d  = win_id;
          tx_data_d   = win_data;
          req_ready_d = NUM_REQ'(1) << win_id;
          tx_start_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d    = BUSY;
        busy_cnt_d = '0;
      end
      BUSY: begin
        // tx_done takes precedence over a coincident b_tick.
        if (tx_done) begin
          if (GAP_TICKS == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else if (b_tick) begin
          busy_cnt_d = busy_cnt + 1'b1;
          if (busy_cnt_d == BUSY_W'(TIMEOUT_TICKS)) begin
            state_d       = IDLE;
            err_timeout_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (b_tick) begin
          gap_cnt_d = gap_cnt + 1'b1;
          if (gap_cnt_d == GAP_W'(GAP_TICKS)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_ptr    <= ID_W'(NUM_REQ - 1);
      busy_cnt    <= '0;
      gap_cnt     <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      last_ptr    <= last_ptr_d;
      busy_cnt    <= busy_cnt_d;
      gap_cnt     <= gap_cnt_d;
      req_ready   <= req_ready_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_id_d;
      active      <= active_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed, table-driven bench for uart_tx_arbiter (NUM_REQ=3, GAP_TICKS=16,
//   TIMEOUT_TICKS=352). A vector table walks complete transactions through
//   the round-robin pointer; hand-written sequences cover the timeout,
//   same-cycle tx_done/b_tick, stray tx_done and mid-frame reset cases.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 3;
  localparam int GAP_TICKS     = 16;
  localparam int TIMEOUT_TICKS = 352;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_tick;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .GAP_TICKS    (GAP_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .b_tick     (b_tick),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .active     (active),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] data;
    int          done_delay;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sixteen b_ticks must be needed to leave GAP: still active after 15,
  // idle right after the 16th.
  task automatic gap_check(input string tag);
    for (int i = 1; i <= GAP_TICKS; i++) begin
      b_tick = 1'b1;
      tick();
      b_tick = 1'b0;
      if (i == GAP_TICKS - 1) check({tag, ".gap_active"}, active, 1);
      if (i == GAP_TICKS)     check({tag, ".gap_done"},   active, 0);
      tick();
    end
  endtask

  // Grant from IDLE and check the LOAD-cycle outputs.
  task automatic grant(input string tag, input logic [2:0] valid, input logic [23:0] data,
                       input logic [1:0] exp_id, input logic [7:0] exp_data);
    req_valid = valid;
    req_data  = data;
    tick();
    check({tag, ".ready"},    req_ready, 3'b001 << exp_id);
    check({tag, ".start"},    tx_start,  1);
    check({tag, ".data"},     tx_data,   exp_data);
    check({tag, ".grant_id"}, grant_id,  exp_id);
    check({tag, ".active"},   active,    1);
    req_valid = '0;
    tick();
    check({tag, ".ready_off"}, req_ready, 0);
    check({tag, ".start_off"}, tx_start,  0);
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    grant(tag, v.valid, v.data, v.exp_id, v.exp_data);
    repeat (v.done_delay) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check({tag, ".in_gap"},    active,  1);
    check({tag, ".data_hold"}, tx_data, v.exp_data);
    gap_check(tag);
  endtask

  // Grant, then starve tx_done until the busy timeout fires.
  task automatic run_timeout(input string tag, input logic [2:0] valid, input logic [1:0] exp_id,
                             input logic clr_same);
    grant(tag, valid, 24'h302010, exp_id, 8'h10 << (4 * 0) == 8'h10 ? 8'h10 * (exp_id + 1) : 8'h00);
    for (int i = 1; i <= TIMEOUT_TICKS; i++) begin
      b_tick = 1'b1;
      if (i == TIMEOUT_TICKS) err_clr = clr_same;
      tick();
      b_tick  = 1'b0;
      err_clr = 1'b0;
      if (i == TIMEOUT_TICKS - 1) begin
        check({tag, ".pre_active"}, active,      1);
        check({tag, ".pre_err"},    err_timeout, 0);
      end
    end
    check({tag, ".to_idle"}, active,      0);
    check({tag, ".to_err"},  err_timeout, 1);
  endtask

  initial begin
    vecs[0] = '{3'b010, 24'h30A510, 100, 2'd1, 8'hA5};
    vecs[1] = '{3'b111, 24'h302010,   5, 2'd2, 8'h30};
    vecs[2] = '{3'b111, 24'h302010,   5, 2'd0, 8'h10};
    vecs[3] = '{3'b111, 24'h302010,   5, 2'd1, 8'h20};
    vecs[4] = '{3'b111, 24'h302010,   5, 2'd2, 8'h30};
    vecs[5] = '{3'b111, 24'h302010,   5, 2'd0, 8'h10};
    vecs[6] = '{3'b101, 24'h302010,   5, 2'd2, 8'h30};
    vecs[7] = '{3'b101, 24'h302010,   5, 2'd0, 8'h10};
    vecs[8] = '{3'b001, 24'h302010,   3, 2'd0, 8'h10};
    vecs[9] = '{3'b100, 24'h302010,   3, 2'd2, 8'h30};

    rst       = 1'b0;
    b_tick    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    err_clr   = 1'b0;
    repeat (3) tick();
    check("rst.ready",    req_ready,   0);
    check("rst.start",    tx_start,    0);
    check("rst.data",     tx_data,     0);
    check("rst.grant_id", grant_id,    0);
    check("rst.active",   active,      0);
    check("rst.err",      err_timeout, 0);
    rst = 1'b1;
    tick();
    check("idle.active", active, 0);

    // Table: single request, round robin 0,1,2,0, skipping, lone requester.
    for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Timeout, then clear; a grant may follow immediately (no gap).
    run_timeout("to1", 3'b001, 2'd0, 1'b0);
    req_valid = 3'b100;
    req_data  = 24'h302010;
    tick();
    check("to1.nogap_start", tx_start, 1);
    check("to1.nogap_id",    grant_id, 2);
    req_valid = '0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to1.clr", err_timeout, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    gap_check("to1.follow");

    // Timeout coinciding with err_clr keeps the flag set.
    run_timeout("to2", 3'b010, 2'd1, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to2.clr", err_timeout, 0);

    // tx_done coinciding with b_tick in BUSY goes to GAP; stray tx_done in
    // GAP and IDLE is ignored.
    grant("same", 3'b001, 24'h302010, 2'd0, 8'h10);
    tick();
    tx_done = 1'b1;
    b_tick  = 1'b1;
    tick();
    tx_done = 1'b0;
    b_tick  = 1'b0;
    check("same.active", active,      1);
    check("same.err",    err_timeout, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    gap_check("same");
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("stray.idle", active, 0);

    // Reset in BUSY: immediate clear, no reissue, priority pointer reset.
    grant("mid", 3'b010, 24'h302010, 2'd1, 8'h20);
    #2;
    rst = 1'b0;
    #1;
    check("mid.active",   active,   0);
    check("mid.start",    tx_start, 0);
    check("mid.data",     tx_data,  0);
    check("mid.grant_id", grant_id, 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("mid.no_reissue", tx_start, 0);
    check("mid.still_idle", active,   0);
    run_txn("post_rst", '{3'b110, 24'h302010, 3, 2'd1, 8'h20});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
